// File: rtl/sd_host_pkg.sv
// Shared constants, state encoding and byte-merge helper for the SD host CSR block.
package sd_host_pkg;

  localparam int unsigned WORD_IDX_W = 5;

  localparam logic [WORD_IDX_W-1:0] REG_ARG      = 5'd0;
  localparam logic [WORD_IDX_W-1:0] REG_CMD      = 5'd1;
  localparam logic [WORD_IDX_W-1:0] REG_START    = 5'd2;
  localparam logic [WORD_IDX_W-1:0] REG_BLK      = 5'd3;
  localparam logic [WORD_IDX_W-1:0] REG_TIMEOUT  = 5'd4;
  localparam logic [WORD_IDX_W-1:0] REG_IRQ_EN   = 5'd5;
  localparam logic [WORD_IDX_W-1:0] REG_IRQ_STAT = 5'd6;
  localparam logic [WORD_IDX_W-1:0] REG_CTRL     = 5'd7;
  localparam logic [WORD_IDX_W-1:0] REG_RESP0    = 5'd8;
  localparam logic [WORD_IDX_W-1:0] REG_STATUS   = 5'd12;
  localparam logic [WORD_IDX_W-1:0] REG_ELAPSED  = 5'd13;

  localparam int unsigned IRQ_N         = 6;
  localparam int unsigned IRQ_CMD_DONE  = 0;
  localparam int unsigned IRQ_DATA_DONE = 1;
  localparam int unsigned IRQ_TIMEOUT   = 2;
  localparam int unsigned IRQ_OVERRUN   = 3;
  localparam int unsigned IRQ_DET_INS   = 4;
  localparam int unsigned IRQ_DET_REM   = 5;

  localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_ISSUE = 2'd1,
    CMD_WAIT  = 2'd2
  } cmd_state_e;

  // Replace only the bytes of old that are enabled in be.
  function automatic logic [31:0] be_merge(input logic [31:0] old,
                                           input logic [31:0] wd,
                                           input logic [3:0]  be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{be[i]}};
    return (old & ~m) | (wd & m);
  endfunction

endpackage

// File: rtl/sd_host_cmd_fsm.sv
// Command sequencer: request/ack handshake, elapsed counter and timeout abort.
module sd_host_cmd_fsm
  import sd_host_pkg::*;
#(
  parameter int unsigned TMO_W = 32
) (
  input  logic             msoc_clk,
  input  logic             rst,
  input  logic             start_c,
  input  logic             cmd_ack_i,
  input  logic             cmd_done_i,
  input  logic [TMO_W-1:0] timeout,
  output logic             cmd_req_o,
  output logic             cmd_abort_o,
  output logic             busy,
  output logic [TMO_W-1:0] elapsed,
  output logic             done_c,
  output logic             tmo_c,
  output logic             ovr_c
);

  cmd_state_e state_q, state_d;
  logic       clr_elapsed_c;

  always_ff @(posedge msoc_clk) begin
    if (rst) state_q <= CMD_IDLE;
    else     state_q <= state_d;
  end

  // Done takes priority over a coincident timeout.
  always_comb begin
    state_d       = state_q;
    done_c        = 1'b0;
    tmo_c         = 1'b0;
    ovr_c         = 1'b0;
    clr_elapsed_c = 1'b0;
    case (state_q)
      CMD_IDLE: begin
        if (start_c) begin
          state_d       = CMD_ISSUE;
          clr_elapsed_c = 1'b1;
        end
      end
      CMD_ISSUE: begin
        ovr_c = start_c;
        if (cmd_ack_i) state_d = CMD_WAIT;
      end
      CMD_WAIT: begin
        ovr_c = start_c;
        if (cmd_done_i) begin
          done_c  = 1'b1;
          state_d = CMD_IDLE;
        end else if ((timeout != '0) && (elapsed == timeout - TMO_W'(1))) begin
          tmo_c   = 1'b1;
          state_d = CMD_IDLE;
        end
      end
      default: state_d = CMD_IDLE;
    endcase
  end

  always_ff @(posedge msoc_clk) begin
    if (rst) begin
      cmd_req_o   <= 1'b0;
      cmd_abort_o <= 1'b0;
      busy        <= 1'b0;
      elapsed     <= '0;
    end else begin
      cmd_req_o   <= (state_d == CMD_ISSUE);
      cmd_abort_o <= tmo_c;
      busy        <= (state_d != CMD_IDLE);
      if (clr_elapsed_c)
        elapsed <= '0;
      else if ((state_q == CMD_WAIT) && (elapsed != '1))
        elapsed <= elapsed + TMO_W'(1);
    end
  end

endmodule

// File: rtl/sd_host_csr.sv
// SD host control/status register block: bus decode, IRQ logic and response capture.
module sd_host_csr
  import sd_host_pkg::*;
#(
  parameter int unsigned BUS_W      = 64,
  parameter int unsigned TMO_W      = 32,
  parameter int unsigned RESP_WORDS = 4
) (
  input  logic                    msoc_clk,
  input  logic                    rst,
  input  logic                    spisd_en,
  input  logic                    spisd_we,
  input  logic [BUS_W/8-1:0]      spisd_be,
  input  logic [15:0]             spisd_addr,
  input  logic [BUS_W-1:0]        spisd_wrdata,
  output logic [BUS_W-1:0]        spisd_rddata,
  output logic                    cmd_req_o,
  input  logic                    cmd_ack_i,
  input  logic                    cmd_done_i,
  input  logic                    data_done_i,
  output logic                    cmd_abort_o,
  input  logic [32*RESP_WORDS-1:0] resp_i,
  input  logic [31:0]             status_i,
  input  logic                    sd_detect_i,
  output logic [31:0]             cmd_arg_o,
  output logic [5:0]              cmd_idx_o,
  output logic [5:0]              cmd_set_o,
  output logic [15:0]             blkcnt_o,
  output logic [11:0]             blksize_o,
  output logic                    sd_reset_o,
  output logic                    irq_o
);

  logic [WORD_IDX_W-1:0] widx_c;
  logic                  wr_c;
  logic [3:0]            be_c;
  logic [31:0]           wd_c;
  logic                  start_c;

  logic [31:0]      timeout_q;
  logic [IRQ_N-1:0] irq_en_q;
  logic [IRQ_N-1:0] irq_stat_q;
  logic [IRQ_N-1:0] irq_set_c;
  logic [IRQ_N-1:0] irq_clr_c;
  logic [31:0]      resp_q [RESP_WORDS];
  logic [2:0]       det_sync_q;
  logic             det_rise_c;
  logic             det_fall_c;
  logic [31:0]      rd_c;

  logic             busy;
  logic [TMO_W-1:0] elapsed;
  logic             done_c;
  logic             tmo_c;
  logic             ovr_c;

  assign widx_c  = spisd_addr[7:3];
  assign wr_c    = spisd_en & spisd_we & (|spisd_be);
  assign be_c    = spisd_be[3:0];
  assign wd_c    = spisd_wrdata[31:0];
  assign start_c = wr_c && (widx_c == REG_START) && be_c[0] && wd_c[0];

  // Registers live in the low 32 bits of each bus word; the rest is ignored.
  logic unused_bits;
  if (BUS_W > 32) begin : g_wide
    assign unused_bits = ^{spisd_addr[15:8], spisd_addr[2:0],
                           spisd_wrdata[BUS_W-1:32], spisd_be[BUS_W/8-1:4]};
  end else begin : g_narrow
    assign unused_bits = ^{spisd_addr[15:8], spisd_addr[2:0]};
  end

  sd_host_cmd_fsm #(
    .TMO_W(TMO_W)
  ) u_cmd_fsm (
    .msoc_clk   (msoc_clk),
    .rst        (rst),
    .start_c    (start_c),
    .cmd_ack_i  (cmd_ack_i),
    .cmd_done_i (cmd_done_i),
    .timeout    (TMO_W'(timeout_q)),
    .cmd_req_o  (cmd_req_o),
    .cmd_abort_o(cmd_abort_o),
    .busy       (busy),
    .elapsed    (elapsed),
    .done_c     (done_c),
    .tmo_c      (tmo_c),
    .ovr_c      (ovr_c)
  );

  // Writable configuration registers.
  always_ff @(posedge msoc_clk) begin
    if (rst) begin
      cmd_arg_o  <= '0;
      cmd_idx_o  <= '0;
      cmd_set_o  <= '0;
      blkcnt_o   <= '0;
      blksize_o  <= '0;
      timeout_q  <= '0;
      irq_en_q   <= '0;
      sd_reset_o <= 1'b0;
    end else if (wr_c) begin
      case (widx_c)
        REG_ARG:     cmd_arg_o <= be_merge(cmd_arg_o, wd_c, be_c);
        REG_CMD:     {cmd_set_o, cmd_idx_o} <=
                       12'(be_merge({20'b0, cmd_set_o, cmd_idx_o}, wd_c, be_c));
        REG_BLK:     {blksize_o, blkcnt_o} <=
                       28'(be_merge({4'b0, blksize_o, blkcnt_o}, wd_c, be_c));
        REG_TIMEOUT: timeout_q <= be_merge(timeout_q, wd_c, be_c);
        REG_IRQ_EN:  irq_en_q <= 6'(be_merge({26'b0, irq_en_q}, wd_c, be_c));
        REG_CTRL:    sd_reset_o <= 1'(be_merge({31'b0, sd_reset_o}, wd_c, be_c));
        default: ;
      endcase
    end
  end

  // Card-detect synchroniser plus one history flop for edge detection.
  always_ff @(posedge msoc_clk) begin
    if (rst) det_sync_q <= '0;
    else     det_sync_q <= {det_sync_q[1:0], sd_detect_i};
  end

  assign det_rise_c = det_sync_q[1] & ~det_sync_q[2];
  assign det_fall_c = ~det_sync_q[1] & det_sync_q[2];

  always_comb begin
    irq_set_c                = '0;
    irq_set_c[IRQ_CMD_DONE]  = done_c;
    irq_set_c[IRQ_DATA_DONE] = data_done_i;
    irq_set_c[IRQ_TIMEOUT]   = tmo_c;
    irq_set_c[IRQ_OVERRUN]   = ovr_c;
    irq_set_c[IRQ_DET_INS]   = det_rise_c;
    irq_set_c[IRQ_DET_REM]   = det_fall_c;
    irq_clr_c                = '0;
    if (wr_c && (widx_c == REG_IRQ_STAT))
      irq_clr_c = 6'(be_merge(32'h0, wd_c, be_c));
  end

  // Hardware set wins over a same-cycle write-1-to-clear.
  always_ff @(posedge msoc_clk) begin
    if (rst) begin
      irq_stat_q <= '0;
      irq_o      <= 1'b0;
    end else begin
      irq_stat_q <= irq_set_c | (irq_stat_q & ~irq_clr_c);
      irq_o      <= |(irq_en_q & irq_stat_q);
    end
  end

  always_ff @(posedge msoc_clk) begin
    if (rst) begin
      for (int i = 0; i < int'(RESP_WORDS); i++) resp_q[i] <= '0;
    end else if (done_c) begin
      for (int i = 0; i < int'(RESP_WORDS); i++) resp_q[i] <= resp_i[i*32 +: 32];
    end
  end

  always_comb begin
    rd_c = UNMAPPED_DATA;
    case (widx_c)
      REG_ARG:      rd_c = cmd_arg_o;
      REG_CMD:      rd_c = {20'b0, cmd_set_o, cmd_idx_o};
      REG_START:    rd_c = {31'b0, busy};
      REG_BLK:      rd_c = {4'b0, blksize_o, blkcnt_o};
      REG_TIMEOUT:  rd_c = timeout_q;
      REG_IRQ_EN:   rd_c = 32'(irq_en_q);
      REG_IRQ_STAT: rd_c = 32'(irq_stat_q);
      REG_CTRL:     rd_c = {31'b0, sd_reset_o};
      REG_STATUS:   rd_c = status_i;
      REG_ELAPSED:  rd_c = 32'(elapsed);
      default: ;
    endcase
    for (int unsigned i = 0; i < RESP_WORDS; i++) begin
      if (widx_c == REG_RESP0 + 5'(i)) rd_c = resp_q[i];
    end
  end

  always_ff @(posedge msoc_clk) begin
    if (rst)           spisd_rddata <= '0;
    else if (spisd_en) spisd_rddata <= BUS_W'(rd_c);
  end

endmodule

// File: tb/tb_sd_host_csr.sv
// Directed bench for sd_host_csr; a 64-bit and a 32-bit instance share all stimulus.
module tb_sd_host_csr;

  logic         msoc_clk = 1'b0;
  logic         rst;
  logic         spisd_en, spisd_we;
  logic [7:0]   spisd_be;
  logic [15:0]  spisd_addr;
  logic [63:0]  spisd_wrdata;
  logic [63:0]  rd64;
  logic [31:0]  rd32;
  logic         cmd_ack_i, cmd_done_i, data_done_i, sd_detect_i;
  logic [127:0] resp_i;
  logic [31:0]  status_i;

  logic        cmd_req_o, cmd_abort_o, sd_reset_o, irq_o;
  logic [31:0] cmd_arg_o;
  logic [5:0]  cmd_idx_o, cmd_set_o;
  logic [15:0] blkcnt_o;
  logic [11:0] blksize_o;

  logic        req32, abort32, sdrst32, irq32;
  logic [31:0] arg32;
  logic [5:0]  idx32, set32;
  logic [15:0] blkcnt32;
  logic [11:0] blksize32;

  int checks = 0;
  int errors = 0;
  int abort_cnt = 0;

  always #5 msoc_clk = ~msoc_clk;
  always @(posedge msoc_clk) if (cmd_abort_o) abort_cnt <= abort_cnt + 1;

  sd_host_csr #(.BUS_W(64), .TMO_W(32), .RESP_WORDS(4)) dut (
    .msoc_clk(msoc_clk), .rst(rst), .spisd_en(spisd_en), .spisd_we(spisd_we),
    .spisd_be(spisd_be), .spisd_addr(spisd_addr), .spisd_wrdata(spisd_wrdata),
    .spisd_rddata(rd64), .cmd_req_o(cmd_req_o), .cmd_ack_i(cmd_ack_i),
    .cmd_done_i(cmd_done_i), .data_done_i(data_done_i), .cmd_abort_o(cmd_abort_o),
    .resp_i(resp_i), .status_i(status_i), .sd_detect_i(sd_detect_i),
    .cmd_arg_o(cmd_arg_o), .cmd_idx_o(cmd_idx_o), .cmd_set_o(cmd_set_o),
    .blkcnt_o(blkcnt_o), .blksize_o(blksize_o), .sd_reset_o(sd_reset_o), .irq_o(irq_o)
  );

  sd_host_csr #(.BUS_W(32), .TMO_W(32), .RESP_WORDS(4)) dut32 (
    .msoc_clk(msoc_clk), .rst(rst), .spisd_en(spisd_en), .spisd_we(spisd_we),
    .spisd_be(spisd_be[3:0]), .spisd_addr(spisd_addr), .spisd_wrdata(spisd_wrdata[31:0]),
    .spisd_rddata(rd32), .cmd_req_o(req32), .cmd_ack_i(cmd_ack_i),
    .cmd_done_i(cmd_done_i), .data_done_i(data_done_i), .cmd_abort_o(abort32),
    .resp_i(resp_i), .status_i(status_i), .sd_detect_i(sd_detect_i),
    .cmd_arg_o(arg32), .cmd_idx_o(idx32), .cmd_set_o(set32),
    .blkcnt_o(blkcnt32), .blksize_o(blksize32), .sd_reset_o(sdrst32), .irq_o(irq32)
  );

  task automatic tick();
    @(posedge msoc_clk); #1;
  endtask

  task automatic bus_write(input logic [4:0] idx, input logic [31:0] data, input logic [7:0] be);
    spisd_en = 1'b1; spisd_we = 1'b1; spisd_be = be;
    spisd_addr = {8'h00, idx, 3'b000};
    spisd_wrdata = {32'hFFFF_FFFF, data};
    tick();
    spisd_en = 1'b0; spisd_we = 1'b0; spisd_be = '0;
  endtask

  task automatic bus_read(input logic [4:0] idx, output logic [63:0] d64, output logic [31:0] d32);
    spisd_en = 1'b1; spisd_we = 1'b0; spisd_be = '0;
    spisd_addr = {8'h00, idx, 3'b000};
    tick();
    spisd_en = 1'b0;
    d64 = rd64; d32 = rd32;
  endtask

  task automatic start_and_ack();
    bus_write(5'd2, 32'h1, 8'hFF);
    cmd_ack_i = 1'b1;
    tick();
    cmd_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (cmd_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", cmd_req_o); end
    checks++; if (cmd_abort_o !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b expected 0", cmd_abort_o); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq_o); end
    checks++; if (rd64 !== 64'h0) begin errors++; $display("FAIL reset_rddata64: got %h expected 0", rd64); end
    checks++; if (rd32 !== 32'h0) begin errors++; $display("FAIL reset_rddata32: got %h expected 0", rd32); end
    checks++; if ({cmd_arg_o, cmd_idx_o, cmd_set_o, blkcnt_o, blksize_o, sd_reset_o} !== '0) begin
      errors++; $display("FAIL reset_config: got %h expected 0", {cmd_arg_o, cmd_idx_o, cmd_set_o, blkcnt_o, blksize_o, sd_reset_o});
    end
  endtask

  task automatic test_map();
    logic [63:0] d64; logic [31:0] d32;
    bus_read(5'd30, d64, d32);
    checks++; if (d64 !== 64'h0000_0000_DEAD_BEEF) begin errors++; $display("FAIL unmapped64: got %h expected 00000000deadbeef", d64); end
    checks++; if (d32 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL unmapped32: got %h expected deadbeef", d32); end
    bus_write(5'd12, 32'h0, 8'hFF);
    bus_read(5'd12, d64, d32);
    checks++; if (d64 !== 64'h0000_0000_5A5A_C3C3) begin errors++; $display("FAIL status_ro: got %h expected 5a5ac3c3", d64); end
    bus_write(5'd0, 32'hFFFF_FFFF, 8'hFF);
    bus_write(5'd0, 32'h0000_0000, 8'h02);
    checks++; if (cmd_arg_o !== 32'hFFFF_00FF) begin errors++; $display("FAIL arg_be_mask: got %h expected ffff00ff", cmd_arg_o); end
    bus_write(5'd0, 32'h0000_0000, 8'hF0);
    bus_read(5'd0, d64, d32);
    checks++; if (d64 !== 64'h0000_0000_FFFF_00FF) begin errors++; $display("FAIL arg_upper_be: got %h expected ffff00ff", d64); end
    checks++; if (d32 !== 32'hFFFF_00FF) begin errors++; $display("FAIL arg_read32: got %h expected ffff00ff", d32); end
  endtask

  task automatic test_config();
    logic [63:0] d64; logic [31:0] d32;
    bus_write(5'd1, 32'h0000_0A85, 8'hFF);
    checks++; if (cmd_set_o !== 6'h2A || cmd_idx_o !== 6'h05) begin errors++; $display("FAIL cmd_fields: got set %h idx %h expected 2a 05", cmd_set_o, cmd_idx_o); end
    bus_write(5'd3, 32'h0200_0008, 8'hFF);
    checks++; if (blksize_o !== 12'h200 || blkcnt_o !== 16'h0008) begin errors++; $display("FAIL blk_fields: got %h %h expected 200 0008", blksize_o, blkcnt_o); end
    checks++; if (blksize32 !== 12'h200 || blkcnt32 !== 16'h0008) begin errors++; $display("FAIL blk_fields32: got %h %h expected 200 0008", blksize32, blkcnt32); end
    bus_write(5'd7, 32'h1, 8'hFF);
    checks++; if (sd_reset_o !== 1'b1) begin errors++; $display("FAIL ctrl_sd_reset: got %b expected 1", sd_reset_o); end
    bus_read(5'd7, d64, d32);
    checks++; if (d64 !== 64'h1) begin errors++; $display("FAIL ctrl_read: got %h expected 1", d64); end
    bus_write(5'd7, 32'h0, 8'hFF);
  endtask

  task automatic test_cmd_done();
    logic [63:0] d64; logic [31:0] d32;
    int req_cnt; int a0;
    resp_i = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    bus_write(5'd0, 32'h1234_5678, 8'hFF);
    bus_write(5'd1, 32'd17, 8'hFF);
    checks++; if (cmd_arg_o !== 32'h1234_5678 || cmd_idx_o !== 6'd17) begin errors++; $display("FAIL cmd_cfg: got %h %0d expected 12345678 17", cmd_arg_o, cmd_idx_o); end
    a0 = abort_cnt;
    bus_write(5'd2, 32'h1, 8'hFF);
    req_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (cmd_req_o) req_cnt++;
      cmd_ack_i = (req_cnt == 3);
      tick();
    end
    cmd_ack_i = 1'b0;
    checks++; if (req_cnt != 3 || cmd_req_o !== 1'b0) begin errors++; $display("FAIL req_cycles: got %0d (req now %b) expected 3 (0)", req_cnt, cmd_req_o); end
    bus_read(5'd2, d64, d32);
    checks++; if (d64 !== 64'h1) begin errors++; $display("FAIL start_busy: got %h expected 1", d64); end
    repeat (8) tick();
    cmd_done_i = 1'b1;
    tick();
    cmd_done_i = 1'b0;
    bus_read(5'd6, d64, d32);
    checks++; if (d64 !== 64'h01) begin errors++; $display("FAIL done_irq_stat: got %h expected 01", d64); end
    bus_read(5'd8, d64, d32);
    checks++; if (d64 !== 64'h1111_0001) begin errors++; $display("FAIL resp0: got %h expected 11110001", d64); end
    bus_read(5'd11, d64, d32);
    checks++; if (d32 !== 32'h4444_0004) begin errors++; $display("FAIL resp3_32: got %h expected 44440004", d32); end
    bus_read(5'd2, d64, d32);
    checks++; if (d64 !== 64'h0) begin errors++; $display("FAIL start_idle: got %h expected 0", d64); end
    checks++; if (abort_cnt != a0) begin errors++; $display("FAIL done_no_abort: got %0d aborts expected 0", abort_cnt - a0); end
    bus_write(5'd6, 32'h3F, 8'hFF);
  endtask

  task automatic test_timeout();
    logic [63:0] d64; logic [31:0] d32;
    int hit; int a0;
    bus_write(5'd4, 32'd5, 8'hFF);
    a0 = abort_cnt;
    start_and_ack();
    hit = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (cmd_abort_o && hit == 0) hit = k;
    end
    checks++; if (hit != 5) begin errors++; $display("FAIL abort_latency: got %0d expected 5", hit); end
    checks++; if (abort_cnt - a0 != 1) begin errors++; $display("FAIL abort_width: got %0d expected 1", abort_cnt - a0); end
    bus_read(5'd2, d64, d32);
    checks++; if (d64 !== 64'h0) begin errors++; $display("FAIL timeout_idle: got %h expected 0", d64); end
    bus_read(5'd6, d64, d32);
    checks++; if (d64 !== 64'h04) begin errors++; $display("FAIL timeout_irq_stat: got %h expected 04", d64); end
    bus_write(5'd6, 32'h3F, 8'hFF);
  endtask

  task automatic test_done_vs_timeout();
    logic [63:0] d64; logic [31:0] d32;
    int a0;
    bus_write(5'd4, 32'd3, 8'hFF);
    a0 = abort_cnt;
    start_and_ack();
    tick();
    tick();
    cmd_done_i = 1'b1;
    tick();
    cmd_done_i = 1'b0;
    repeat (3) tick();
    checks++; if (abort_cnt != a0) begin errors++; $display("FAIL done_tmo_abort: got %0d aborts expected 0", abort_cnt - a0); end
    bus_read(5'd6, d64, d32);
    checks++; if (d64 !== 64'h01) begin errors++; $display("FAIL done_tmo_stat: got %h expected 01", d64); end
    bus_write(5'd6, 32'h3F, 8'hFF);
    bus_write(5'd4, 32'd0, 8'hFF);
  endtask

  task automatic test_overrun();
    logic [63:0] d64; logic [31:0] d32;
    start_and_ack();
    bus_write(5'd2, 32'h1, 8'hFF);
    bus_read(5'd6, d64, d32);
    checks++; if (d64 !== 64'h08) begin errors++; $display("FAIL overrun_stat: got %h expected 08", d64); end
    bus_read(5'd2, d64, d32);
    checks++; if (d64 !== 64'h1 || cmd_req_o !== 1'b0) begin errors++; $display("FAIL overrun_state: got busy %h req %b expected 1 0", d64, cmd_req_o); end
    cmd_done_i = 1'b1;
    tick();
    cmd_done_i = 1'b0;
    bus_read(5'd6, d64, d32);
    checks++; if (d64 !== 64'h09) begin errors++; $display("FAIL overrun_done_stat: got %h expected 09", d64); end
    data_done_i = 1'b1;
    bus_write(5'd6, 32'h0B, 8'hFF);
    data_done_i = 1'b0;
    bus_read(5'd6, d64, d32);
    checks++; if (d64 !== 64'h02) begin errors++; $display("FAIL set_wins_w1c: got %h expected 02", d64); end
    checks++; if (d32 !== 32'h02) begin errors++; $display("FAIL set_wins_w1c32: got %h expected 02", d32); end
    bus_write(5'd6, 32'h3F, 8'hFF);
  endtask

  task automatic test_detect();
    logic [63:0] d64; logic [31:0] d32;
    int hit;
    bus_write(5'd5, 32'h10, 8'hFF);
    sd_detect_i = 1'b1;
    hit = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (irq_o && hit == 0) hit = k;
    end
    checks++; if (hit < 3 || hit > 4) begin errors++; $display("FAIL detect_irq_latency: got %0d expected 3..4", hit); end
    bus_write(5'd6, 32'h10, 8'hFF);
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_hold_one: got %b expected 1", irq_o); end
    tick();
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq_o); end
    sd_detect_i = 1'b0;
    repeat (5) tick();
    bus_read(5'd6, d64, d32);
    checks++; if (d64 !== 64'h20 || irq_o !== 1'b0) begin errors++; $display("FAIL detect_fall: got stat %h irq %b expected 20 0", d64, irq_o); end
    bus_write(5'd6, 32'h3F, 8'hFF);
    bus_write(5'd5, 32'h0, 8'hFF);
  endtask

  task automatic test_reset_mid();
    logic [63:0] d64; logic [31:0] d32;
    int a0;
    bus_write(5'd0, 32'hA5A5_A5A5, 8'hFF);
    bus_write(5'd7, 32'h1, 8'hFF);
    bus_write(5'd5, 32'h02, 8'hFF);
    data_done_i = 1'b1;
    tick();
    data_done_i = 1'b0;
    tick();
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL data_done_irq: got %b expected 1", irq_o); end
    start_and_ack();
    bus_read(5'd30, d64, d32);
    a0 = abort_cnt;
    rst = 1'b1;
    tick();
    checks++; if ({cmd_req_o, cmd_abort_o, irq_o, sd_reset_o} !== 4'b0) begin errors++; $display("FAIL rst_mid_ctl: got %b expected 0000", {cmd_req_o, cmd_abort_o, irq_o, sd_reset_o}); end
    checks++; if (cmd_arg_o !== 32'h0 || rd64 !== 64'h0 || rd32 !== 32'h0) begin errors++; $display("FAIL rst_mid_data: got arg %h rd %h rd32 %h expected 0", cmd_arg_o, rd64, rd32); end
    checks++; if (req32 !== 1'b0 || arg32 !== 32'h0) begin errors++; $display("FAIL rst_mid_32: got req %b arg %h expected 0", req32, arg32); end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    checks++; if (abort_cnt != a0) begin errors++; $display("FAIL rst_no_abort: got %0d aborts expected 0", abort_cnt - a0); end
    bus_read(5'd6, d64, d32);
    checks++; if (d64 !== 64'h0) begin errors++; $display("FAIL rst_irq_stat: got %h expected 0", d64); end
    bus_read(5'd2, d64, d32);
    checks++; if (d64 !== 64'h0) begin errors++; $display("FAIL rst_state_idle: got %h expected 0", d64); end
  endtask

  initial begin
    rst = 1'b1;
    spisd_en = 1'b0; spisd_we = 1'b0; spisd_be = '0;
    spisd_addr = '0; spisd_wrdata = '0;
    cmd_ack_i = 1'b0; cmd_done_i = 1'b0; data_done_i = 1'b0; sd_detect_i = 1'b0;
    resp_i = '0;
    status_i = 32'h5A5A_C3C3;
    repeat (3) tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_map();
    test_config();
    test_cmd_done();
    test_timeout();
    test_done_vs_timeout();
    test_overrun();
    test_detect();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
